// File: rtl/shift_pkg.sv
// Shared types and helpers for the right-shift datapath: the serializer and
// the combinational shifter use the same zero-fill shift.
package shift_pkg;

    typedef enum logic {IDLE, SHIFT} ser_state_t;

    localparam int DEF_WIDTH = 5;
    localparam int MAX_W     = 64;

    // Logical right shift by one, MSB zero-filled. Callers zero-extend to MAX_W.
    function automatic logic [MAX_W-1:0] shr1(input logic [MAX_W-1:0] x);
        return x >> 1;
    endfunction

endpackage

// File: rtl/right_shift_serializer.sv
// Accepts a parallel word on a valid/ready handshake and streams it LSB-first,
// one bit per accepted beat, with last/done framing for the serial consumer.
module right_shift_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic [WIDTH-1:0] shreg,
    output logic             busy,
    output logic             done
);

    ser_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             last_beat;

    assign in_ready  = (state == IDLE);
    assign ser_valid = (state == SHIFT);
    assign busy      = (state == SHIFT);
    assign ser_bit   = shreg[0];
    assign ser_last  = (state == SHIFT) && (cnt == CNT_W'(1));
    assign last_beat = ser_valid && ser_ready && (cnt == CNT_W'(1));

    // done is high only in the cycle after the final beat, which is also the
    // first IDLE cycle, so a waiting word is taken back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in_data;
                        cnt   <= CNT_W'(WIDTH);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_ready) begin
                        shreg <= WIDTH'(shr1(MAX_W'(shreg)));
                        cnt   <= cnt - CNT_W'(1);
                        if (last_beat) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_right_shift_serializer.sv
// Directed bench for right_shift_serializer (WIDTH=5): framing, backpressure,
// ignored loads, reset abort, back-to-back words and a random scoreboard.
module tb_right_shift_serializer;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         ser_valid;
    logic         ser_ready;
    logic         ser_bit;
    logic         ser_last;
    logic [W-1:0] shreg;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    right_shift_serializer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .ser_valid(ser_valid),
        .ser_ready(ser_ready),
        .ser_bit  (ser_bit),
        .ser_last (ser_last),
        .shreg    (shreg),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] w);
        chk("load_rdy", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = w;
        step();
        in_valid = 1'b0;
    endtask

    // Checks beats 'from'..W-1 with ser_ready=1; optionally pokes in_valid at one beat.
    task automatic run_beats(input logic [W-1:0] w, input int from, input int poke);
        logic [W-1:0] sr;
        for (int i = from; i < W; i++) begin
            sr = w >> i;
            chk("beat_vld",   32'(ser_valid), 1);
            chk("beat_bit",   32'(ser_bit),   32'(sr[0]));
            chk("beat_shreg", 32'(shreg),     32'(sr));
            chk("beat_last",  32'(ser_last),  32'(i == W - 1));
            if (i == poke) begin
                in_valid = 1'b1;
                in_data  = 5'b11111;
                chk("poke_rdy", 32'(in_ready), 0);
            end
            step();
            in_valid = 1'b0;
        end
        chk("done_hi",    32'(done),      1);
        chk("done_shreg", 32'(shreg),     0);
        chk("done_vld",   32'(ser_valid), 0);
        chk("done_rdy",   32'(in_ready),  1);
        step();
        chk("done_lo",    32'(done),      0);
    endtask

    logic [W-1:0] exp1 [W];
    logic [9:0]   bits10;
    int           nb, ndone, nlast, k;
    logic         drop;
    logic [W-1:0] word, rebuilt;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; ser_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_rdy",   32'(in_ready),  1);
        chk("rst_vld",   32'(ser_valid), 0);
        chk("rst_busy",  32'(busy),      0);
        chk("rst_last",  32'(ser_last),  0);
        chk("rst_shreg", 32'(shreg),     0);
        chk("rst_done",  32'(done),      0);

        // 1: 11011, hand-computed shift sequence
        exp1[0] = 5'b11011; exp1[1] = 5'b01101; exp1[2] = 5'b00110;
        exp1[3] = 5'b00011; exp1[4] = 5'b00001;
        load(5'b11011);
        for (int i = 0; i < W; i++) begin
            chk("t1_shreg", 32'(shreg),    32'(exp1[i]));
            chk("t1_busy",  32'(busy),     1);
            chk("t1_last",  32'(ser_last), 32'(i == 4));
            step();
        end
        chk("t1_done",  32'(done),  1);
        chk("t1_zero",  32'(shreg), 0);
        step();
        chk("t1_done1", 32'(done),  0);

        // 2: 00110 with 3 stalled cycles on bit 2
        load(5'b00110);
        chk("t2_b1", 32'(ser_bit), 0);
        step();
        ser_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_bit",   32'(ser_bit),   1);
            chk("t2_hold_shreg", 32'(shreg),     32'(5'b00011));
            chk("t2_hold_vld",   32'(ser_valid), 1);
            chk("t2_hold_done",  32'(done),      0);
            step();
        end
        ser_ready = 1'b1;
        run_beats(5'b00110, 1, -1);

        // 3: 10101 with a load attempt during SHIFT
        load(5'b10101);
        run_beats(5'b10101, 0, 2);

        // 4: reset after two accepted bits of 01111
        load(5'b01111);
        chk("t4_b1", 32'(ser_bit), 1); step();
        chk("t4_b2", 32'(ser_bit), 1); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_vld",   32'(ser_valid), 0);
        chk("t4_shreg", 32'(shreg),     0);
        chk("t4_done",  32'(done),      0);
        step();
        chk("t4_done2", 32'(done),      0);
        chk("t4_vld2",  32'(ser_valid), 0);
        load(5'b00001);
        run_beats(5'b00001, 0, -1);

        // 5: back-to-back 00000 then 11111, in_valid held
        nb = 0; ndone = 0; bits10 = '0;
        in_valid = 1'b1; in_data = 5'b00000;
        step();
        in_data = 5'b11111;
        for (int c = 0; c < 14; c++) begin
            drop = 1'b0;
            if (ser_valid) begin
                if (nb < 10) bits10[nb] = ser_bit;
                nb++;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    chk("t5_acc_rdy", 32'(in_ready), 1);
                    drop = 1'b1;
                end
            end
            step();
            if (drop) in_valid = 1'b0;
        end
        chk("t5_nbits", 32'(nb),     10);
        chk("t5_ndone", 32'(ndone),  2);
        chk("t5_bits",  32'(bits10), 32'(10'b1111100000));

        // 6: random words, random backpressure
        for (int n = 0; n < 8; n++) begin
            word = W'($urandom);
            load(word);
            k = 0; nlast = 0; rebuilt = '0;
            for (int c = 0; c < 200 && k < W; c++) begin
                ser_ready = 1'($urandom_range(0, 1));
                if (ser_valid && ser_ready) begin
                    rebuilt[k] = ser_bit;
                    if (ser_last) nlast++;
                    k++;
                end
                step();
            end
            ser_ready = 1'b1;
            chk("t6_beats", 32'(k),       W);
            chk("t6_word",  32'(rebuilt), 32'(word));
            chk("t6_last",  32'(nlast),   1);
            chk("t6_done",  32'(done),    1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
